// File: rtl/motor_register_bank.sv
// Avalon-MM register bank for the motor-board UART block: per-motor config with optional
// shadow/commit, status snapshots, host-silence watchdog and bad-address counting.
module motor_register_bank #(
  parameter int          NUM_MOTORS      = 6,
  parameter bit          SHADOWED        = 1'b1,
  parameter int unsigned WATCHDOG_CYCLES = 50_000_000,
  parameter logic [31:0] ID_VALUE        = 32'hB15B00B6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              address,
  input  logic                     write,
  input  logic [31:0]              writedata,
  input  logic                     read,
  output logic [31:0]              readdata,
  output logic                     waitrequest,
  input  logic                     status_valid,
  input  logic [NUM_MOTORS*32-1:0] status_position,
  input  logic [NUM_MOTORS*32-1:0] status_velocity,
  input  logic [NUM_MOTORS*32-1:0] status_pwm,
  input  logic [NUM_MOTORS*32-1:0] status_error,
  output logic [NUM_MOTORS*32-1:0] Kp,
  output logic [NUM_MOTORS*32-1:0] Ki,
  output logic [NUM_MOTORS*32-1:0] Kd,
  output logic [NUM_MOTORS*32-1:0] sp,
  output logic [NUM_MOTORS*32-1:0] PWMLimit,
  output logic [NUM_MOTORS*32-1:0] IntegralLimit,
  output logic [NUM_MOTORS*32-1:0] deadband,
  output logic [NUM_MOTORS*8-1:0]  control_mode,
  output logic                     watchdog_tripped
);

  // Config slot order: 0 Kp, 1 Ki, 2 Kd, 3 PWMLimit, 4 IntegralLimit, 5 deadband, 6 control_mode, 7 sp
  typedef logic [7:0][31:0] cfg_t;
  localparam cfg_t CFG_RESET = {32'd0, 32'd0, 32'd0, 32'd50, 32'd127, 32'd0, 32'd0, 32'd1};
  localparam logic [2:0] SLOT_MODE = 3'd6;
  localparam logic [2:0] SLOT_SP   = 3'd7;

  function automatic logic [3:0] cfg_decode(input logic [7:0] r);
    case (r)
      8'h01:   return 4'b1000;
      8'h02:   return 4'b1001;
      8'h03:   return 4'b1010;
      8'h08:   return 4'b1011;
      8'h09:   return 4'b1100;
      8'h0A:   return 4'b1101;
      8'h0B:   return 4'b1110;
      8'h0C:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Status slot order: 0 position, 1 velocity, 2 pwm, 3 error
  function automatic logic [2:0] st_decode(input logic [7:0] r);
    case (r)
      8'h04:   return 3'b100;
      8'h06:   return 3'b101;
      8'h17:   return 3'b110;
      8'h0D:   return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  cfg_t             shd_q [NUM_MOTORS];
  cfg_t             shd_d [NUM_MOTORS];
  cfg_t             act_q [NUM_MOTORS];
  cfg_t             act_d [NUM_MOTORS];
  logic [3:0][31:0] st_q  [NUM_MOTORS];
  logic [3:0][31:0] st_d  [NUM_MOTORS];
  logic [31:0]      bad_cnt_q, bad_cnt_d;
  logic [31:0]      wd_cnt_q, wd_cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rd_phase_q, rd_phase_d;
  logic             trip_q, trip_d;

  logic [7:0]  reg_f, mot_f;
  logic        mot_ok, cfg_hit, st_hit;
  logic [2:0]  cfg_idx;
  logic [1:0]  st_idx;
  logic        rd_accept, wr_accept, rd_bad, wr_bad, wd_expire;
  logic [31:0] rd_val, wr_data;

  always_comb begin
    reg_f     = address[15:8];
    mot_f     = address[7:0];
    mot_ok    = {1'b0, mot_f} < 9'(NUM_MOTORS);
    {cfg_hit, cfg_idx} = cfg_decode(reg_f);
    {st_hit, st_idx}   = st_decode(reg_f);
    rd_accept = read && !rd_phase_q;
    // A write colliding with a read is dropped; the read wins.
    wr_accept = write && !read;
    wr_data   = (cfg_idx == SLOT_MODE) ? {24'b0, writedata[7:0]} : writedata;

    rd_val = 32'hDEADBEEF;
    rd_bad = 1'b1;
    case (reg_f)
      8'h00:   begin rd_val = ID_VALUE;          rd_bad = 1'b0; end
      8'h20:   begin rd_val = '0;                rd_bad = 1'b0; end
      8'h21:   begin rd_val = {31'b0, trip_q};   rd_bad = 1'b0; end
      8'h22:   begin rd_val = bad_cnt_q;         rd_bad = 1'b0; end
      8'h23:   begin rd_val = 32'(NUM_MOTORS);   rd_bad = 1'b0; end
      default: ;
    endcase
    for (int m = 0; m < NUM_MOTORS; m++) begin
      if (mot_f == 8'(m)) begin
        if (cfg_hit) begin
          rd_val = SHADOWED ? shd_q[m][cfg_idx] : act_q[m][cfg_idx];
          rd_bad = 1'b0;
        end
        if (st_hit) begin
          rd_val = st_q[m][st_idx];
          rd_bad = 1'b0;
        end
      end
    end
    wr_bad = !((cfg_hit && mot_ok) || reg_f == 8'h20 || reg_f == 8'h21);

    shd_d      = shd_q;
    act_d      = act_q;
    st_d       = st_q;
    trip_d     = trip_q;
    wd_cnt_d   = wd_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    wd_expire  = 1'b0;
    rd_phase_d = rd_accept;
    rdata_d    = rd_accept ? rd_val : rdata_q;

    if (((rd_accept && rd_bad) || (wr_accept && wr_bad)) && bad_cnt_q != '1)
      bad_cnt_d = bad_cnt_q + 32'd1;

    // Any accepted write, good or bad, counts as host activity and beats expiry.
    if (WATCHDOG_CYCLES != 0) begin
      if (wr_accept)                                      wd_cnt_d  = '0;
      else if (wd_cnt_q == 32'(WATCHDOG_CYCLES - 1))      wd_expire = 1'b1;
      else                                                wd_cnt_d  = wd_cnt_q + 32'd1;
    end
    if (wd_expire) trip_d = 1'b1;
    if (wr_accept && reg_f == 8'h21 && writedata[0]) trip_d = 1'b0;

    for (int m = 0; m < NUM_MOTORS; m++) begin
      if (status_valid)
        st_d[m] = {status_error[32*m +: 32], status_pwm[32*m +: 32],
                   status_velocity[32*m +: 32], status_position[32*m +: 32]};
      if (wr_accept && cfg_hit && mot_f == 8'(m)) begin
        shd_d[m][cfg_idx] = wr_data;
        if (!SHADOWED) act_d[m][cfg_idx] = wr_data;
      end
      if (SHADOWED && wr_accept && reg_f == 8'h20 && m < 32 && writedata[m % 32])
        act_d[m] = shd_q[m];
      if (wd_expire) begin
        shd_d[m][SLOT_MODE] = '0;
        shd_d[m][SLOT_SP]   = '0;
        act_d[m][SLOT_MODE] = '0;
        act_d[m][SLOT_SP]   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int m = 0; m < NUM_MOTORS; m++) begin
        shd_q[m] <= CFG_RESET;
        act_q[m] <= CFG_RESET;
        st_q[m]  <= '0;
      end
      bad_cnt_q  <= '0;
      wd_cnt_q   <= '0;
      rdata_q    <= '0;
      rd_phase_q <= 1'b0;
      trip_q     <= 1'b0;
    end else begin
      shd_q      <= shd_d;
      act_q      <= act_d;
      st_q       <= st_d;
      bad_cnt_q  <= bad_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      rdata_q    <= rdata_d;
      rd_phase_q <= rd_phase_d;
      trip_q     <= trip_d;
    end
  end

  // Gating with reset keeps a read held across reset from stalling during the reset cycle.
  assign waitrequest      = read && !rd_phase_q && !reset;
  assign readdata         = rdata_q;
  assign watchdog_tripped = trip_q;

  for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_out
    assign Kp[32*g +: 32]            = act_q[g][0];
    assign Ki[32*g +: 32]            = act_q[g][1];
    assign Kd[32*g +: 32]            = act_q[g][2];
    assign PWMLimit[32*g +: 32]      = act_q[g][3];
    assign IntegralLimit[32*g +: 32] = act_q[g][4];
    assign deadband[32*g +: 32]      = act_q[g][5];
    assign control_mode[8*g +: 8]    = act_q[g][6][7:0];
    assign sp[32*g +: 32]            = act_q[g][7];
  end

endmodule

// File: doc/motor_register_bank.md
Name: motor_register_bank

Overview:
Parametrised Avalon-MM register bank sitting between the HPS/Nios bus and the motor-board UART communication block. It serves NUM_MOTORS motor channels with per-motor control parameters and status snapshots. Compared with the previous control bank it adds:
- optional shadow/commit for atomic multi-motor updates
- a host-silence watchdog that safes all motors
- bad-address accounting
- a fixed, deterministic read latency

Parameters:
NUM_MOTORS, 6, motor channels (1..256)
SHADOWED, 1, 1 = writes land in shadow, become active on COMMIT; 0 = writes go active immediately
WATCHDOG_CYCLES, 50_000_000, clk cycles without any bus write before safing; 0 disables
ID_VALUE, 32'hB15B00B6, value returned at register 0x00

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
address  in  16  [15:8] register, [7:0] motor index
write  in  1  Avalon write strobe
writedata  in  32  write data (signed)
read  in  1  Avalon read strobe
readdata  out  32  read data
waitrequest  out  1  read stall
status_valid  in  1  one-cycle strobe: sample all status inputs
status_position  in  NUM_MOTORS*32  encoder position, motor m at [32m+31:32m]
status_velocity  in  NUM_MOTORS*32  encoder velocity
status_pwm  in  NUM_MOTORS*32  applied pwm
status_error  in  NUM_MOTORS*32  error code
Kp, Ki, Kd, sp, PWMLimit, IntegralLimit, deadband  out  NUM_MOTORS*32 each  active config
control_mode  out  NUM_MOTORS*8  active control mode
watchdog_tripped  out  1  sticky safing flag

Behaviour:
Register map. Per-motor registers use address[7:0] as the motor index.
- Config, RW: 0x01 Kp, 0x02 Ki, 0x03 Kd, 0x08 PWMLimit, 0x09 IntegralLimit, 0x0A deadband, 0x0B control_mode (low 8 bits stored, read back zero-extended), 0x0C sp.
- Status, RO: 0x04 position, 0x06 velocity, 0x17 pwm, 0x0D error.

Global registers ignore the motor field:
- 0x00 ID, RO.
- 0x20 COMMIT, WO: writedata[m]=1 copies shadow to active for motor m; bits >= NUM_MOTORS are ignored.
- 0x21 WDOG: read {31'b0, watchdog_tripped}; writing bit0=1 clears the flag.
- 0x22 BADADDR_CNT, RO, saturating 32-bit.
- 0x23 NUM_MOTORS, RO.

Reset (synchronous) values:
- Kp=1; Ki=Kd=sp=deadband=control_mode=0; PWMLimit=127; IntegralLimit=50. Applies to both shadow and active copies.
- Status snapshots, BADADDR_CNT and the watchdog counter are 0; watchdog_tripped=0.
- readdata=0, waitrequest=0 while read=0.

Read handshake, fixed 2-cycle:
- Cycle 0: read=1, waitrequest=1, address is sampled and readdata is registered.
- Cycle 1: waitrequest=0, readdata is valid, transaction completes.
- readdata holds until the next read completes. Back-to-back reads take 2 cycles each.
- waitrequest = read && !rd_phase, where rd_phase toggles 0→1 on accept and returns to 0 on completion.

Read data sources:
- Config reads return the shadow copy when SHADOWED=1, otherwise the active copy.
- Unmapped register, or motor index >= NUM_MOTORS on a per-motor register: readdata=32'hDEADBEEF and BADADDR_CNT+1.

Write handshake:
- Writes never stall; accepted in any cycle with write=1 && read=0.
- write && read in the same cycle is a protocol violation: the write is dropped and the read proceeds.
- Writes to RO registers, unmapped registers, or motor >= NUM_MOTORS are ignored and BADADDR_CNT+1.

Shadow/commit:
- With SHADOWED=0, config writes update shadow and active together in the same cycle, and COMMIT is a no-op.
- A COMMIT updates all selected motors in the same cycle (atomic). Active outputs change on the clock edge after COMMIT is accepted.

Status capture:
- status_valid=1 latches all four status vectors for all motors in one cycle.
- A read accepted in the same cycle returns the pre-capture value.

Watchdog:
- The counter increments each cycle and clears on any accepted write, including bad-address writes.
- When the counter reaches WATCHDOG_CYCLES-1:
  - watchdog_tripped is set;
  - for all motors, active and shadow control_mode are forced to 0 and sp to 0;
  - the counter holds.
- While tripped, control_mode/sp writes are still accepted; the flag stays set until cleared via 0x21.
- If an accepted write and expiry fall in the same cycle, the write wins and no trip occurs.
- WATCHDOG_CYCLES=0: counter idle, never trips.

Reset mid-read: waitrequest drops and rd_phase=0; the aborted read returns no data.

Test Plan:
1. Reset, then read 0x0100, 0x0800, 0x0900, 0x0000 → 1, 127, 50, 0xB15B00B6; each read shows exactly one cycle of waitrequest=1.
2. SHADOWED=1: write 0x0C02=1000 and 0x0C04=-500 → sp outputs for motors 2/4 stay 0 while reading 0x0C02 returns 1000; write 0x2000=0x14 → next cycle sp[2]=1000 and sp[4]=-500 simultaneously, other motors unchanged.
3. Read 0x0106 and write 0x0109 (motor >= 6) and read 0x3000 → read data 0xDEADBEEF, BADADDR_CNT=3, no config output changes.
4. WATCHDOG_CYCLES=100: write control_mode=2, sp=300 to motor 0 and commit, then stay idle for 100 cycles → watchdog_tripped=1, control_mode[0]=0, sp[0]=0; write 0x2100=1 → flag clears. Repeat with a write on cycle 99 → no trip.
5. Pulse status_valid with position[3]=0x7FFFFFFF while a read of 0x0403 is accepted in the same cycle → old value returned; the next read returns 0x7FFFFFFF.
6. Assert reset while waitrequest=1 → waitrequest=0 next cycle and all registers return to their reset values.
